// File: rtl/a_decoder_scan.sv
// 1-of-N active-low decoder with three enables and an auto-scan mode
// that walks the low output through every index, holding each one for a programmable dwell.
module a_decoder_scan #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8,
  localparam int N_OUT  = 2**SEL_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               g1_en_i,
  input  logic               g2a_en_n_i,
  input  logic               g2b_en_n_i,
  input  logic               mode_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [N_OUT-1:0]   yn_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               active_o,
  output logic               wrap_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic [N_OUT-1:0] ONE_HOT_BASE = N_OUT'(1);
  localparam logic [SEL_W-1:0] LAST_IDX     = '1;

  state_t               state_q, state_nxt;
  logic [SEL_W-1:0]     index_q, index_nxt;
  logic [DWELL_W-1:0]   cnt_q, cnt_nxt;
  logic [N_OUT-1:0]     yn_nxt;
  logic [SEL_W-1:0]     sel_nxt;
  logic                 active_nxt;
  logic                 wrap_nxt;
  logic                 enable_s;

  assign enable_s = g1_en_i & ~g2a_en_n_i & ~g2b_en_n_i;

  // Outputs are computed for the state being entered, so they appear one edge after the inputs.
  always_comb begin
    state_nxt  = IDLE;
    index_nxt  = index_q;
    cnt_nxt    = cnt_q;
    yn_nxt     = '1;
    sel_nxt    = sel_o;
    active_nxt = 1'b0;
    wrap_nxt   = 1'b0;

    if (enable_s) begin
      state_nxt = mode_i ? SCAN : DIRECT;
    end

    unique case (state_nxt)
      DIRECT: begin
        index_nxt  = sel_i;
        cnt_nxt    = '0;
        yn_nxt     = ~(ONE_HOT_BASE << sel_i);
        sel_nxt    = sel_i;
        active_nxt = 1'b1;
      end
      SCAN: begin
        if (state_q != SCAN) begin
          index_nxt = sel_i;
          cnt_nxt   = dwell_i;
        end else if (cnt_q != '0) begin
          cnt_nxt = cnt_q - DWELL_W'(1);
        end else begin
          // Only a genuine advance out of the last index counts as a wrap.
          index_nxt = index_q + SEL_W'(1);
          cnt_nxt   = dwell_i;
          wrap_nxt  = (index_q == LAST_IDX);
        end
        yn_nxt     = ~(ONE_HOT_BASE << index_nxt);
        sel_nxt    = index_nxt;
        active_nxt = 1'b1;
      end
      default: begin
        yn_nxt = '1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      index_q  <= '0;
      cnt_q    <= '0;
      yn_o     <= '1;
      sel_o    <= '0;
      active_o <= 1'b0;
      wrap_o   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      index_q  <= index_nxt;
      cnt_q    <= cnt_nxt;
      yn_o     <= yn_nxt;
      sel_o    <= sel_nxt;
      active_o <= active_nxt;
      wrap_o   <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_a_decoder_scan.sv
// Directed bench for a_decoder_scan: default 3-bit select instance plus a 4-bit select instance
// for the wide-decode and wrap corner.
module tb_a_decoder_scan;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i, g1_en_i, g2a_en_n_i, g2b_en_n_i, mode_i;
  logic [2:0] sel_i;
  logic [7:0] dwell_i;
  logic [7:0] yn_o;
  logic [2:0] sel_o;
  logic       active_o, wrap_o;

  logic        rst16, g1_16, g2a_n16, g2b_n16, mode16;
  logic [3:0]  sel16;
  logic [7:0]  dwell16;
  logic [15:0] yn16;
  logic [3:0]  sel_o16;
  logic        active16, wrap16;

  int vectors = 0;
  int miscompares = 0;

  a_decoder_scan dut (
    .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i), .g1_en_i(g1_en_i),
    .g2a_en_n_i(g2a_en_n_i), .g2b_en_n_i(g2b_en_n_i), .mode_i(mode_i),
    .dwell_i(dwell_i), .yn_o(yn_o), .sel_o(sel_o), .active_o(active_o), .wrap_o(wrap_o)
  );

  a_decoder_scan #(.SEL_W(4), .DWELL_W(8)) dut16 (
    .clk_i(clk_i), .rst_i(rst16), .sel_i(sel16), .g1_en_i(g1_16),
    .g2a_en_n_i(g2a_n16), .g2b_en_n_i(g2b_n16), .mode_i(mode16),
    .dwell_i(dwell16), .yn_o(yn16), .sel_o(sel_o16), .active_o(active16), .wrap_o(wrap16)
  );

  task automatic applyStimulus(input logic rst, input logic g1, input logic g2a_n,
                               input logic g2b_n, input logic mode,
                               input logic [2:0] sel, input logic [7:0] dwell);
    rst_i      = rst;
    g1_en_i    = g1;
    g2a_en_n_i = g2a_n;
    g2b_en_n_i = g2b_n;
    mode_i     = mode;
    sel_i      = sel;
    dwell_i    = dwell;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] exp_yn,
                             input logic [2:0] exp_sel, input logic exp_active,
                             input logic exp_wrap);
    vectors++;
    assert (yn_o === exp_yn) else begin
      miscompares++;
      $error("[TB] FAIL %s yn_o observed=%h expected=%h", tag, yn_o, exp_yn);
    end
    vectors++;
    assert (sel_o === exp_sel) else begin
      miscompares++;
      $error("[TB] FAIL %s sel_o observed=%0d expected=%0d", tag, sel_o, exp_sel);
    end
    vectors++;
    assert (active_o === exp_active) else begin
      miscompares++;
      $error("[TB] FAIL %s active_o observed=%b expected=%b", tag, active_o, exp_active);
    end
    vectors++;
    assert (wrap_o === exp_wrap) else begin
      miscompares++;
      $error("[TB] FAIL %s wrap_o observed=%b expected=%b", tag, wrap_o, exp_wrap);
    end
  endtask

  task automatic checkOutput16(input string tag, input logic [15:0] exp_yn,
                               input logic [3:0] exp_sel, input logic exp_active,
                               input logic exp_wrap);
    vectors++;
    assert (yn16 === exp_yn) else begin
      miscompares++;
      $error("[TB] FAIL %s yn_o observed=%h expected=%h", tag, yn16, exp_yn);
    end
    vectors++;
    assert (sel_o16 === exp_sel) else begin
      miscompares++;
      $error("[TB] FAIL %s sel_o observed=%0d expected=%0d", tag, sel_o16, exp_sel);
    end
    vectors++;
    assert (active16 === exp_active) else begin
      miscompares++;
      $error("[TB] FAIL %s active_o observed=%b expected=%b", tag, active16, exp_active);
    end
    vectors++;
    assert (wrap16 === exp_wrap) else begin
      miscompares++;
      $error("[TB] FAIL %s wrap_o observed=%b expected=%b", tag, wrap16, exp_wrap);
    end
  endtask

  initial begin
    rst16 = 1'b1; g1_16 = 1'b1; g2a_n16 = 1'b0; g2b_n16 = 1'b0;
    mode16 = 1'b0; sel16 = 4'd0; dwell16 = 8'd0;

    // Reset wins over fully enabled SCAN request
    applyStimulus(1, 1, 0, 0, 1, 3'd3, 8'd5);
    checkOutput("reset", 8'hFF, 3'd0, 0, 0);
    checkOutput16("reset16", 16'hFFFF, 4'd0, 0, 0);

    // DIRECT decode, then disable holds sel_o
    applyStimulus(0, 1, 0, 0, 0, 3'd5, 8'd0);
    checkOutput("direct5", 8'hDF, 3'd5, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 3'd5, 8'd0);
    checkOutput("g2a_off", 8'hFF, 3'd5, 0, 0);

    // SCAN dwell 0 from 6: wrap flagged only on advance into 0
    applyStimulus(0, 1, 0, 0, 1, 3'd6, 8'd0);
    checkOutput("scan6", 8'hBF, 3'd6, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd6, 8'd0);
    checkOutput("scan7", 8'h7F, 3'd7, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd6, 8'd0);
    checkOutput("scan_wrap", 8'hFE, 3'd0, 1, 1);
    applyStimulus(0, 1, 0, 0, 1, 3'd6, 8'd0);
    checkOutput("scan1", 8'hFD, 3'd1, 1, 0);

    // Go idle, then SCAN from 0 with dwell 2; dwell change mid-FD applies at next reload
    applyStimulus(0, 0, 0, 0, 1, 3'd0, 8'd2);
    checkOutput("g1_off", 8'hFF, 3'd1, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'd2);
    checkOutput("dw_fe_a", 8'hFE, 3'd0, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'd2);
    checkOutput("dw_fe_b", 8'hFE, 3'd0, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'd2);
    checkOutput("dw_fe_c", 8'hFE, 3'd0, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'd2);
    checkOutput("dw_fd_a", 8'hFD, 3'd1, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'd0);
    checkOutput("dw_fd_b", 8'hFD, 3'd1, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'd0);
    checkOutput("dw_fd_c", 8'hFD, 3'd1, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'd0);
    checkOutput("dw_fb", 8'hFB, 3'd2, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'd0);
    checkOutput("dw_f7", 8'hF7, 3'd3, 1, 0);

    // One-cycle disable at index 3, re-entry restarts from sel_i without wrap
    applyStimulus(0, 1, 0, 1, 1, 3'd0, 8'd0);
    checkOutput("g2b_off", 8'hFF, 3'd3, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'd0);
    checkOutput("reenter0", 8'hFE, 3'd0, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'd0);
    checkOutput("re_fd", 8'hFD, 3'd1, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'd3);
    checkOutput("re_fb", 8'hFB, 3'd2, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd0, 8'd3);
    checkOutput("re_fb_hold", 8'hFB, 3'd2, 1, 0);

    // Reset mid-dwell, then SCAN entry from fresh sel_i
    applyStimulus(1, 1, 0, 0, 1, 3'd0, 8'd3);
    checkOutput("mid_reset", 8'hFF, 3'd0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd4, 8'd0);
    checkOutput("scan4", 8'hEF, 3'd4, 1, 0);

    // SCAN -> DIRECT -> SCAN: no scan position retained
    applyStimulus(0, 1, 0, 0, 0, 3'd7, 8'd0);
    checkOutput("to_direct7", 8'h7F, 3'd7, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd6, 8'd0);
    checkOutput("rescan6", 8'hBF, 3'd6, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd6, 8'd0);
    checkOutput("rescan7", 8'h7F, 3'd7, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 3'd6, 8'd0);
    checkOutput("rescan_wrap", 8'hFE, 3'd0, 1, 1);

    // Wide instance: DIRECT 15, then SCAN from 15 wraps to 0
    rst16 = 1'b0; mode16 = 1'b0; sel16 = 4'd15; dwell16 = 8'd0;
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 8'd0);
    checkOutput16("w_direct15", 16'h7FFF, 4'd15, 1, 0);
    mode16 = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 8'd0);
    checkOutput16("w_scan15", 16'h7FFF, 4'd15, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 8'd0);
    checkOutput16("w_wrap", 16'hFFFE, 4'd0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 8'd0);
    checkOutput16("w_scan1", 16'hFFFD, 4'd1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/a_decoder_scan.md
A_DECODER_SCAN -- requirements
Module: a_decoder_scan

Interface
REQ-001 Parameter SEL_W, default 3: select width; the block SHALL have N_OUT = 2**SEL_W outputs.
REQ-002 Parameter DWELL_W, default 8: dwell counter width.
REQ-003 clk_i  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 sel_i  input  SEL_W  decode index (DIRECT) / start index (SCAN).
REQ-006 g1_en_i  input  1  enable, active-high.
REQ-007 g2a_en_n_i  input  1  enable, active-low.
REQ-008 g2b_en_n_i  input  1  enable, active-low.
REQ-009 mode_i  input  1  0 = DIRECT, 1 = SCAN.
REQ-010 dwell_i  input  DWELL_W  SCAN hold time minus one, in cycles.
REQ-011 yn_o  output  N_OUT  decoded outputs, active-low, registered.
REQ-012 sel_o  output  SEL_W  index currently driven low.
REQ-013 active_o  output  1  high when exactly one yn_o bit is low.
REQ-014 wrap_o  output  1  one-cycle pulse on SCAN wrap-around.

Function
REQ-015 The block SHALL form enable_s = g1_en_i AND NOT g2a_en_n_i AND NOT g2b_en_n_i, evaluated every cycle.
REQ-016 The FSM SHALL have states IDLE, DIRECT and SCAN; next state is IDLE if enable_s=0, DIRECT if enable_s=1 and mode_i=0, SCAN if enable_s=1 and mode_i=1.
REQ-017 All outputs SHALL be registered: one cycle latency from sampled inputs to yn_o, sel_o, active_o and wrap_o.
REQ-018 IDLE: yn_o all ones, active_o=0, sel_o holds its last value, wrap_o=0.
REQ-019 DIRECT: at each edge yn_o SHALL become the bitwise inverse of (1 << sel_i), sel_o = sel_i, active_o=1.
REQ-020 On entry to SCAN from IDLE or DIRECT, the block SHALL load index = sel_i and cnt = dwell_i.
REQ-021 In SCAN, while cnt != 0, the block SHALL decrement cnt; when cnt == 0 it SHALL set index = (index + 1) mod N_OUT and reload cnt from dwell_i.
REQ-022 In SCAN, each index SHALL be held low for dwell_i + 1 cycles; dwell_i=0 SHALL advance every cycle.
REQ-023 dwell_i SHALL be sampled only at load and reload; mid-dwell changes take effect at the next reload.
REQ-024 wrap_o SHALL be 1 only during the cycle where sel_o first equals 0 after advancing from N_OUT-1; an entry load to index 0 SHALL NOT assert wrap_o.
REQ-025 In SCAN, yn_o SHALL be the inverse of (1 << index), sel_o = index, active_o=1.
REQ-026 SCAN to DIRECT: the next cycle SHALL show the DIRECT decode of sel_i; cnt is discarded.
REQ-027 Leaving SCAN then re-entering SHALL restart from sel_i; no scan position is retained.
REQ-028 At most one yn_o bit SHALL be low in any cycle.
REQ-029 Arithmetic SHALL be unsigned; index wraps modulo N_OUT and cnt never underflows.

Reset
REQ-030 When rst_i=1 at an edge, the block SHALL enter IDLE with yn_o all ones, sel_o=0, active_o=0, wrap_o=0, cnt=0, index=0, regardless of other inputs.
REQ-031 rst_i SHALL take priority over enable_s and mode_i, including mid-SCAN and mid-dwell.

Verification
REQ-032 Reset with all enables active, mode_i=1 -> next cycle yn_o=8'hFF, sel_o=0, active_o=0, wrap_o=0.
REQ-033 DIRECT, sel_i=5 -> next cycle yn_o=8'hDF, sel_o=5; then g2a_en_n_i=1 -> next cycle yn_o=8'hFF, sel_o=5.
REQ-034 SCAN, dwell_i=0, sel_i=6 -> yn_o per cycle BF, 7F, FE, FD; wrap_o=1 only in the FE cycle.
REQ-035 SCAN, dwell_i=2, sel_i=0 -> FE for 3 cycles, then FD for 3 cycles; change dwell_i to 0 mid-FD -> FD still held 3 cycles, FB held 1 cycle.
REQ-036 Mid-SCAN at index 3: disable one cycle -> FF; re-enable SCAN with sel_i=0 -> FE, no wrap_o. Mid-SCAN rst_i pulse -> FF, sel_o=0.
REQ-037 SEL_W=4, DIRECT, sel_i=15 -> yn_o=16'h7FFF; SCAN from 15, dwell_i=0 -> 16'hFFFE next cycle with wrap_o=1.
